// File: rtl/debug_req_ctrl.sv
// Halt/resume handshake controller between the debug transport and the core.
// Define DEBUG_REQ_TIMEOUT_EN to add the handshake timeout counter, ERROR state and timeout_o.
module debug_req_ctrl #(
    parameter int unsigned TIMEOUT_W      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_i,
    input  logic haltreq_i,
    input  logic resumereq_i,
    input  logic debug_mode_i,
    input  logic clear_i,
    output logic debug_req_o,
    output logic resume_req_o,
    output logic halted_o,
    output logic resumeack_o,
    output logic timeout_o,
    output logic spurious_o
);

    if ((TIMEOUT_CYCLES == 0) ||
        (64'(TIMEOUT_CYCLES) > ((64'(1) << TIMEOUT_W) - 64'(1)))) begin : g_param_check
        $error("TIMEOUT_CYCLES must lie in 1..2**TIMEOUT_W-1");
    end

`ifdef DEBUG_REQ_TIMEOUT_EN
    typedef enum logic [2:0] {
        StRunning,
        StHaltReq,
        StHalted,
        StResumeReq,
        StError
    } state_e;
`else
    typedef enum logic [1:0] {
        StRunning,
        StHaltReq,
        StHalted,
        StResumeReq
    } state_e;
`endif

    state_e state_q, state_d;
    logic   spurious_q, spurious_d;
    logic   resumeack_d;
    logic   debug_req_q, resume_req_q, halted_q, resumeack_q;
    logic   in_error;
    logic   limit_hit;

`ifdef DEBUG_REQ_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] CntLimit = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 timeout_q, timeout_d;
    logic                 in_handshake;

    assign in_handshake = (state_q == StHaltReq) || (state_q == StResumeReq);
    assign limit_hit    = (cnt_q == CntLimit);
    assign in_error     = (state_q == StError);

    // Clear on entry, then count up and saturate while a handshake is pending.
    always_comb begin
        cnt_d = cnt_q;
        if (!in_handshake && ((state_d == StHaltReq) || (state_d == StResumeReq))) begin
            cnt_d = '0;
        end else if (in_handshake && (cnt_q != '1)) begin
            cnt_d = cnt_q + TIMEOUT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign limit_hit = 1'b0;
    assign in_error  = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        spurious_d  = spurious_q;
        resumeack_d = 1'b0;
`ifdef DEBUG_REQ_TIMEOUT_EN
        timeout_d   = timeout_q;
`endif
        // A new spurious entry in the same cycle takes precedence over the clear.
        if (clear_i && !in_error) begin
            spurious_d = 1'b0;
        end

        unique case (state_q)
            StRunning: begin
                if (haltreq_i) begin
                    state_d = StHaltReq;
                end else if (debug_mode_i) begin
                    state_d    = StHalted;
                    spurious_d = 1'b1;
                end
            end
            StHaltReq: begin
                if (debug_mode_i) begin
                    state_d = StHalted;
                end else if (limit_hit) begin
`ifdef DEBUG_REQ_TIMEOUT_EN
                    state_d   = StError;
                    timeout_d = 1'b1;
`endif
                end
            end
            StHalted: begin
                if (resumereq_i) begin
                    state_d = StResumeReq;
                end
            end
            StResumeReq: begin
                if (!debug_mode_i) begin
                    state_d     = StRunning;
                    resumeack_d = 1'b1;
                end else if (limit_hit) begin
`ifdef DEBUG_REQ_TIMEOUT_EN
                    state_d   = StError;
                    timeout_d = 1'b1;
`endif
                end
            end
`ifdef DEBUG_REQ_TIMEOUT_EN
            StError: begin
                if (clear_i) begin
                    state_d   = StRunning;
                    timeout_d = 1'b0;
                end
            end
`endif
            default: state_d = StRunning;
        endcase
    end

    // Outputs are decoded from the next state so each one is a flop.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StRunning;
            spurious_q   <= 1'b0;
            debug_req_q  <= 1'b0;
            resume_req_q <= 1'b0;
            halted_q     <= 1'b0;
            resumeack_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            spurious_q   <= spurious_d;
            debug_req_q  <= (state_d == StHaltReq);
            resume_req_q <= (state_d == StResumeReq);
            halted_q     <= (state_d == StHalted);
            resumeack_q  <= resumeack_d;
        end
    end

    assign debug_req_o  = debug_req_q;
    assign resume_req_o = resume_req_q;
    assign halted_o     = halted_q;
    assign resumeack_o  = resumeack_q;
    assign spurious_o   = spurious_q;

endmodule

// File: tb/tb_debug_req_ctrl.sv
// Scoreboard bench for debug_req_ctrl: directed handshake scenarios followed by random stimulus.
module tb_debug_req_ctrl;

    localparam int unsigned TW = 8;
    localparam int unsigned TC = 4;
`ifdef DEBUG_REQ_TIMEOUT_EN
    localparam bit ToEn = 1'b1;
`else
    localparam bit ToEn = 1'b0;
`endif

    localparam int PRun = 0, PHreq = 1, PHalted = 2, PRreq = 3, PErr = 4;

    logic clk = 1'b0;
    logic rst_i, haltreq_i, resumereq_i, debug_mode_i, clear_i;
    logic debug_req_o, resume_req_o, halted_o, resumeack_o, timeout_o, spurious_o;

    debug_req_ctrl #(
        .TIMEOUT_W      (TW),
        .TIMEOUT_CYCLES (TC)
    ) dut (
        .clk          (clk),
        .rst_i        (rst_i),
        .haltreq_i    (haltreq_i),
        .resumereq_i  (resumereq_i),
        .debug_mode_i (debug_mode_i),
        .clear_i      (clear_i),
        .debug_req_o  (debug_req_o),
        .resume_req_o (resume_req_o),
        .halted_o     (halted_o),
        .resumeack_o  (resumeack_o),
        .timeout_o    (timeout_o),
        .spurious_o   (spurious_o)
    );

    always #5 clk = ~clk;

    int         vectors = 0;
    int         errors  = 0;
    logic [5:0] exp_q[$];

    // Reference model: phase of the handshake, cycles spent waiting, sticky flags.
    int phase  = PRun;
    int waited = 0;
    bit m_spur = 1'b0;
    bit m_tmo  = 1'b0;

    function automatic logic [5:0] outs();
        return {debug_req_o, resume_req_o, halted_o, resumeack_o, timeout_o, spurious_o};
    endfunction

    task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b (dreq,rreq,halted,ack,tmo,spur)",
                     name, $time, act, exp);
        end
    endtask

    task automatic model_step(input bit h, input bit r, input bit dm, input bit clr);
        int old;
        bit ack;
        old = phase;
        ack = 1'b0;
        if (clr && old != PErr) m_spur = 1'b0;
        case (old)
            PRun: begin
                if (h) begin
                    phase = PHreq; waited = 0;
                end else if (dm) begin
                    phase = PHalted; m_spur = 1'b1;
                end
            end
            PHreq: begin
                if (dm) phase = PHalted;
                else if (ToEn && waited == int'(TC) - 1) begin
                    phase = PErr; m_tmo = 1'b1;
                end else waited++;
            end
            PHalted: begin
                if (r) begin
                    phase = PRreq; waited = 0;
                end
            end
            PRreq: begin
                if (!dm) begin
                    phase = PRun; ack = 1'b1;
                end else if (ToEn && waited == int'(TC) - 1) begin
                    phase = PErr; m_tmo = 1'b1;
                end else waited++;
            end
            default: begin
                if (clr) begin
                    phase = PRun; m_tmo = 1'b0;
                end
            end
        endcase
        exp_q.push_back({phase == PHreq, phase == PRreq, phase == PHalted, ack, m_tmo, m_spur});
    endtask

    // Called just after a falling edge; applies one cycle of stimulus.
    task automatic drive(input bit h, input bit r, input bit dm, input bit clr);
        haltreq_i    = h;
        resumereq_i  = r;
        debug_mode_i = dm;
        clear_i      = clr;
        model_step(h, r, dm, clr);
        @(negedge clk);
    endtask

    task automatic do_reset(input bit dm);
        rst_i        = 1'b1;
        haltreq_i    = 1'b0;
        resumereq_i  = 1'b0;
        clear_i      = 1'b0;
        debug_mode_i = dm;
        #1;
        chk("reset_async", outs(), 6'b0);
        phase  = PRun;
        waited = 0;
        m_spur = 1'b0;
        m_tmo  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        chk("reset_release", outs(), 6'b0);
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst_i && exp_q.size() != 0) begin
            chk("outputs", outs(), exp_q.pop_front());
            chk("req_exclusive", {5'b0, debug_req_o & resume_req_o}, 6'b0);
        end
    end

    initial begin
        bit dm_r;
        rst_i        = 1'b1;
        haltreq_i    = 1'b0;
        resumereq_i  = 1'b0;
        debug_mode_i = 1'b0;
        clear_i      = 1'b0;
        @(negedge clk);

        // Debug mode already high across reset: no action until the first edge.
        do_reset(1'b1);
        drive(0, 0, 1, 0);
        drive(0, 0, 1, 1);
        drive(1, 0, 1, 0);

        // Resume with debug mode dropping two cycles later.
        drive(0, 1, 1, 0);
        drive(0, 0, 1, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);

        // Simultaneous halt and resume: halt wins; request survives haltreq dropping.
        drive(1, 1, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 1, 0);
        drive(0, 0, 1, 0);

        // Reset in the middle of a resume handshake.
        drive(0, 1, 1, 0);
        drive(0, 0, 1, 0);
        do_reset(1'b0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);

        // Completion on the same cycle the counter reaches its limit.
        drive(1, 0, 0, 0);
        repeat (3) drive(0, 0, 0, 0);
        drive(0, 0, 1, 0);

        // Stalled resume, then clear.
        drive(0, 1, 1, 0);
        repeat (6) drive(0, 0, 1, 0);
        drive(0, 0, 1, 1);
        drive(0, 0, 0, 0);

        // Long stalled halt.
        drive(1, 0, 0, 0);
        repeat (1000) drive(0, 0, 0, 0);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);

        dm_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset(1'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 3) == 0) dm_r = ~dm_r;
            drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), dm_r,
                  1'($urandom_range(0, 15) == 0));
        end

        @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drained: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
